// File: rtl/led_strip_pkg.sv
// led_strip_pkg: pixel width, FSM state codes and default WS2812 timing.
// Build option: define WS2812_RGBW_EN for 32-bit SK6812 GRBW pixels.
`default_nettype none

package led_strip_pkg;

`ifdef WS2812_RGBW_EN
    localparam int PIXEL_W = 32;
`else
    localparam int PIXEL_W = 24;
`endif

    localparam int DEF_T0H_CYC   = 40;
    localparam int DEF_T1H_CYC   = 80;
    localparam int DEF_BIT_CYC   = 125;
    localparam int DEF_RESET_CYC = 6000;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_LATCH = 2'd2;

    // Wide enough to hold the larger of the two terminal counts itself.
    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ws2812_bit_cell.sv
// ws2812_bit_cell: produces one NRZ bit period per start strobe on a registered data line.
// Build option WS2812_RGBW_EN does not affect this cell.
`default_nettype none

module ws2812_bit_cell #(
    parameter int T0H_CYC = 40,
    parameter int T1H_CYC = 80,
    parameter int BIT_CYC = 125,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic bit_i,
    output logic dout_o,
    output logic done_o
);

    localparam logic [CNT_W-1:0] C_T0H  = CNT_W'(T0H_CYC);
    localparam logic [CNT_W-1:0] C_T1H  = CNT_W'(T1H_CYC);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(BIT_CYC - 1);

    logic             active_q;
    logic [CNT_W-1:0] cyc_q;
    logic             dout_q;
    logic [CNT_W-1:0] thr;

    assign thr    = bit_i ? C_T1H : C_T0H;
    assign done_o = active_q && (cyc_q == C_LAST);
    assign dout_o = dout_q;

    // The data line is registered, so it trails the cycle counter by one clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            cyc_q    <= '0;
            dout_q   <= 1'b0;
        end else begin
            dout_q <= active_q && (cyc_q < thr);
            if (start_i) begin
                active_q <= 1'b1;
                cyc_q    <= '0;
            end else if (done_o) begin
                active_q <= 1'b0;
                cyc_q    <= '0;
            end else if (active_q) begin
                cyc_q <= cyc_q + CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ws2812_bit_encoder.sv
// ws2812_bit_encoder: serialises GRB(W) pixels into WS2812 NRZ with a latch gap per frame.
// Build option: WS2812_RGBW_EN selects 32-bit pixels (via led_strip_pkg).
`default_nettype none

module ws2812_bit_encoder
    import led_strip_pkg::*;
#(
    parameter int T0H_CYC   = DEF_T0H_CYC,
    parameter int T1H_CYC   = DEF_T1H_CYC,
    parameter int BIT_CYC   = DEF_BIT_CYC,
    parameter int RESET_CYC = DEF_RESET_CYC
) (
    input  logic               ACLK,
    input  logic               ARESETN,
    input  logic [PIXEL_W-1:0] s_pixel,
    input  logic               s_last,
    input  logic               s_valid,
    output logic               s_ready,
    output logic               led_dout,
    output logic               busy,
    output logic               frame_done,
    output logic               underrun
);

    localparam int CNT_W = cnt_width(BIT_CYC, RESET_CYC);
    localparam int IDX_W = $clog2(PIXEL_W);
    localparam logic [IDX_W-1:0] IDX_TOP   = IDX_W'(PIXEL_W - 1);
    localparam logic [CNT_W-1:0] LATCH_END = CNT_W'(RESET_CYC);

    logic [1:0]         state_q, state_d;
    logic [PIXEL_W-1:0] shreg_q, shreg_d;
    logic               sh_last_q, sh_last_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [PIXEL_W-1:0] buf_q, buf_d;
    logic               buf_last_q, buf_last_d;
    logic               buf_full_q, buf_full_d;
    logic [CNT_W-1:0]   latch_q, latch_d;
    logic               frame_done_q, frame_done_d;
    logic               underrun_q, underrun_d;
    logic               load, accept, cell_start, cell_done;

    assign accept     = s_valid && !buf_full_q;
    assign s_ready    = !buf_full_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = frame_done_q;
    assign underrun   = underrun_q;

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        sh_last_d    = sh_last_q;
        idx_d        = idx_q;
        buf_d        = buf_q;
        buf_last_d   = buf_last_q;
        buf_full_d   = buf_full_q;
        latch_d      = latch_q;
        frame_done_d = 1'b0;
        underrun_d   = 1'b0;
        load         = 1'b0;
        cell_start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (buf_full_q) begin
                    load    = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cell_done) begin
                    if (idx_q != '0) begin
                        idx_d      = idx_q - IDX_W'(1);
                        shreg_d    = {shreg_q[PIXEL_W-2:0], 1'b0};
                        cell_start = 1'b1;
                    end else if (sh_last_q) begin
                        state_d = ST_LATCH;
                        latch_d = '0;
                    end else if (buf_full_q) begin
                        load = 1'b1;
                    end else begin
                        state_d    = ST_IDLE;
                        underrun_d = 1'b1;
                    end
                end
            end
            ST_LATCH: begin
                if (latch_q == LATCH_END) begin
                    state_d      = ST_IDLE;
                    frame_done_d = 1'b1;
                end else begin
                    latch_d = latch_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A reload re-arms the bit cell on the same edge, so pixels abut without a gap.
        if (load) begin
            shreg_d    = buf_q;
            sh_last_d  = buf_last_q;
            idx_d      = IDX_TOP;
            cell_start = 1'b1;
        end
        if (accept) begin
            buf_d      = s_pixel;
            buf_last_d = s_last;
            buf_full_d = 1'b1;
        end else if (load) begin
            buf_full_d = 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            sh_last_q    <= 1'b0;
            idx_q        <= '0;
            buf_q        <= '0;
            buf_last_q   <= 1'b0;
            buf_full_q   <= 1'b0;
            latch_q      <= '0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            sh_last_q    <= sh_last_d;
            idx_q        <= idx_d;
            buf_q        <= buf_d;
            buf_last_q   <= buf_last_d;
            buf_full_q   <= buf_full_d;
            latch_q      <= latch_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
        end
    end

    ws2812_bit_cell #(
        .T0H_CYC (T0H_CYC),
        .T1H_CYC (T1H_CYC),
        .BIT_CYC (BIT_CYC),
        .CNT_W   (CNT_W)
    ) u_bit_cell (
        .clk     (ACLK),
        .rst_n   (ARESETN),
        .start_i (cell_start),
        .bit_i   (shreg_q[PIXEL_W-1]),
        .dout_o  (led_dout),
        .done_o  (cell_done)
    );

endmodule

`default_nettype wire

// File: tb/tb_ws2812_bit_encoder.sv
// tb_ws2812_bit_encoder: directed self-checking bench for ws2812_bit_encoder.
// Honours WS2812_RGBW_EN through led_strip_pkg::PIXEL_W.
`default_nettype none

module tb_ws2812_bit_encoder;
    import led_strip_pkg::*;

    localparam int T0H   = 40;
    localparam int T1H   = 80;
    localparam int BITC  = 125;
    localparam int RSTC  = 6000;
    localparam int LIMIT = 20000;

`ifdef WS2812_RGBW_EN
    localparam logic [PIXEL_W-1:0] P_SINGLE = 32'h0000_00FF;
`else
    localparam logic [PIXEL_W-1:0] P_SINGLE = 24'hFF0000;
`endif
    localparam logic [PIXEL_W-1:0] P_A     = PIXEL_W'(32'h00AA_AAAA);
    localparam logic [PIXEL_W-1:0] P_5     = PIXEL_W'(32'h0055_5555);
    localparam logic [PIXEL_W-1:0] P_UR    = PIXEL_W'(32'h0000_0001);
    localparam logic [PIXEL_W-1:0] P_ONES  = '1;
    localparam logic [PIXEL_W-1:0] P_AFTER = PIXEL_W'(32'h0000_F0F0);

    logic               ACLK;
    logic               ARESETN;
    logic [PIXEL_W-1:0] s_pixel;
    logic               s_last;
    logic               s_valid;
    logic               s_ready;
    logic               led_dout;
    logic               busy;
    logic               frame_done;
    logic               underrun;

    int total = 0;
    int bad   = 0;

    ws2812_bit_encoder #(
        .T0H_CYC   (T0H),
        .T1H_CYC   (T1H),
        .BIT_CYC   (BITC),
        .RESET_CYC (RSTC)
    ) dut (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .s_pixel    (s_pixel),
        .s_last     (s_last),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .led_dout   (led_dout),
        .busy       (busy),
        .frame_done (frame_done),
        .underrun   (underrun)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one pixel and returns on the negedge after the accepting edge.
    task automatic send(input logic [PIXEL_W-1:0] px, input logic last);
        int n = 0;
        s_pixel = px;
        s_last  = last;
        s_valid = 1'b1;
        while (!s_ready && n < LIMIT) begin
            @(negedge ACLK);
            n++;
        end
        chk("send_ready", 64'(n < LIMIT), 64'd1);
        @(posedge ACLK);
        @(negedge ACLK);
        s_valid = 1'b0;
    endtask

    // Decodes one pixel from led_dout; ends on the negedge following its last bit period.
    task automatic measure(input string tag, input logic [PIXEL_W-1:0] exp,
                           input bit wait_first, output int ur_idx);
        int n = 0;
        int hc;
        int shape = 0;
        logic prev;
        logic [PIXEL_W-1:0] got = '0;
        ur_idx = -1;
        if (wait_first) begin
            while (led_dout !== 1'b1 && n < LIMIT) begin
                @(negedge ACLK);
                n++;
            end
            chk({tag, "_rise"}, 64'(n < LIMIT), 64'd1);
        end else begin
            chk({tag, "_nogap"}, 64'(led_dout), 64'd1);
        end
        for (int b = 0; b < PIXEL_W; b++) begin
            hc   = 0;
            prev = 1'b1;
            for (int c = 0; c < BITC; c++) begin
                if (led_dout === 1'b1) begin
                    hc++;
                    if (!prev) shape++;
                end
                if (c == 0 && led_dout !== 1'b1) shape++;
                prev = led_dout;
                if (underrun === 1'b1 && ur_idx < 0) ur_idx = b * BITC + c;
                @(negedge ACLK);
            end
            got[PIXEL_W-1-b] = (hc == T1H);
            if (hc != T1H && hc != T0H) shape++;
        end
        chk({tag, "_word"}, 64'(got), 64'(exp));
        chk({tag, "_shape"}, 64'(shape), 64'd0);
    endtask

    task automatic latch_check(input string tag);
        int cnt = 0;
        int lowbad = 0;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        while (frame_done !== 1'b1 && cnt < RSTC + 1000) begin
            if (led_dout !== 1'b0) lowbad++;
            @(negedge ACLK);
            cnt++;
        end
        chk({tag, "_fd_at"}, 64'(cnt), 64'(RSTC));
        chk({tag, "_gap_low"}, 64'(lowbad), 64'd0);
        chk({tag, "_busy_fd"}, 64'(busy), 64'd0);
        @(negedge ACLK);
        chk({tag, "_fd_width"}, 64'(frame_done), 64'd0);
    endtask

    initial begin
        int ur;
        int errs;
        int fdc;
        int n;
        ARESETN = 1'b0;
        s_pixel = '0;
        s_last  = 1'b0;
        s_valid = 1'b0;
        repeat (3) @(negedge ACLK);
        chk("rst_dout", 64'(led_dout), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(s_ready), 64'd1);
        chk("rst_pulses", 64'({frame_done, underrun}), 64'd0);
        ARESETN = 1'b1;

        // Idle after reset release
        errs = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge ACLK);
            if (led_dout !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b1) errs++;
        end
        chk("idle_quiet", 64'(errs), 64'd0);

        // Single last pixel
        send(P_SINGLE, 1'b1);
        chk("p1_pre_rise", 64'(led_dout), 64'd0);
        measure("p1", P_SINGLE, 1'b1, ur);
        chk("p1_no_underrun", 64'(ur), 64'hFFFF_FFFF_FFFF_FFFF);
        latch_check("p1");

        // Back-to-back pair, second last
        send(P_A, 1'b0);
        send(P_5, 1'b1);
        measure("bb0", P_A, 1'b1, ur);
        measure("bb1", P_5, 1'b0, ur);
        latch_check("bb");
        fdc = 0;
        for (int i = 0; i < 200; i++) begin
            if (frame_done === 1'b1) fdc++;
            @(negedge ACLK);
        end
        chk("bb_one_fd", 64'(fdc), 64'd0);

        // Non-last pixel with no follower
        send(P_UR, 1'b0);
        measure("ur", P_UR, 1'b1, ur);
        chk("ur_idx", 64'(ur), 64'(PIXEL_W * BITC - 1));
        chk("ur_width", 64'(underrun), 64'd0);
        chk("ur_idle", 64'(busy), 64'd0);
        fdc = 0;
        for (int i = 0; i < RSTC + 500; i++) begin
            if (frame_done === 1'b1) fdc++;
            @(negedge ACLK);
        end
        chk("ur_no_fd", 64'(fdc), 64'd0);

        // Asynchronous reset part-way through bit 10
        send(P_ONES, 1'b0);
        n = 0;
        while (led_dout !== 1'b1 && n < LIMIT) begin
            @(negedge ACLK);
            n++;
        end
        repeat (10 * BITC + 30) @(negedge ACLK);
        chk("ar_pre_high", 64'(led_dout), 64'd1);
        #2 ARESETN = 1'b0;
        #1;
        chk("ar_dout", 64'(led_dout), 64'd0);
        chk("ar_busy", 64'(busy), 64'd0);
        chk("ar_ready", 64'(s_ready), 64'd1);
        repeat (3) @(negedge ACLK);
        ARESETN = 1'b1;
        send(P_AFTER, 1'b1);
        measure("ar_new", P_AFTER, 1'b1, ur);
        latch_check("ar_new");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
